// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : shared display-mode constants and timing helpers
// Revision       : 1.0
// ============================================================================
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_cfg_t;

  typedef struct packed {
    axis_cfg_t h;
    axis_cfg_t v;
  } mode_cfg_t;

  localparam mode_cfg_t XGA_1024X768_60 = '{
    h: '{active: 1024, fp: 24, sync: 136, bp: 160},
    v: '{active: 768,  fp: 3,  sync: 6,   bp: 29}
  };

  localparam mode_cfg_t SVGA_800X600_60 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88},
    v: '{active: 600, fp: 1,  sync: 4,   bp: 23}
  };

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timing_axis.sv
`default_nettype none
// ============================================================================
// timing_axis : one raster axis (counter + blank/sync decode), flags registered
//               from the next-state count so they always match the shown count
// Revision    : 1.0
// ============================================================================
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160,
  parameter bit POL    = 1'b1,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap,
  output logic             blnk_nxt
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > (1 << CNT_W)) begin : g_bad_width
    $error("timing_axis: total %0d does not fit in %0d-bit counter", TOTAL, CNT_W);
  end

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BLNK_START = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic [CNT_W-1:0] count_nxt;
  logic             sync_nxt;

  assign wrap = (count == LAST);

  // Clear wins over step so a restart lands on zero even while stalled.
  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (step) begin
      count_nxt = wrap ? '0 : count + CNT_W'(1);
    end
  end

  assign blnk_nxt = (count_nxt >= BLNK_START);
  assign sync_nxt = ((count_nxt >= SYNC_START) && (count_nxt <= SYNC_END)) ? POL : ~POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~POL;
    end else if (step || clear) begin
      count <= count_nxt;
      blnk  <= blnk_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : parametrised raster timing generator (counters, sync,
//                  blanking, data enable, line/frame start strobes)
// Revision       : 1.0
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = XGA_1024X768_60.h.active,
  parameter int H_FP      = XGA_1024X768_60.h.fp,
  parameter int H_SYNC    = XGA_1024X768_60.h.sync,
  parameter int H_BP      = XGA_1024X768_60.h.bp,
  parameter int V_ACTIVE  = XGA_1024X768_60.v.active,
  parameter int V_FP      = XGA_1024X768_60.v.fp,
  parameter int V_SYNC    = XGA_1024X768_60.v.sync,
  parameter int V_BP      = XGA_1024X768_60.v.bp,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 12
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  logic h_wrap;
  logic v_wrap;
  logic h_blnk_nxt;
  logic v_blnk_nxt;
  logic v_step;
  logic advance;

  assign v_step  = en & h_wrap;
  assign advance = en | restart;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk      (pclk),
    .rst_n    (reset),
    .step     (en),
    .clear    (restart),
    .count    (hcount),
    .blnk     (hblnk),
    .sync     (hsync),
    .wrap     (h_wrap),
    .blnk_nxt (h_blnk_nxt)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk      (pclk),
    .rst_n    (reset),
    .step     (v_step),
    .clear    (restart),
    .count    (vcount),
    .blnk     (vblnk),
    .sync     (vsync),
    .wrap     (v_wrap),
    .blnk_nxt (v_blnk_nxt)
  );

  // The next position is (0,0) exactly when restarting or wrapping, so the
  // strobes come from the wrap terminals rather than re-decoding the counts.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      de          <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else if (advance) begin
      de          <= ~h_blnk_nxt & ~v_blnk_nxt;
      line_start  <= restart | h_wrap;
      frame_start <= restart | (h_wrap & v_wrap);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : directed self-checking bench, XGA default and tiny mode
// Revision          : 1.0
// ============================================================================
module tb_vga_timing_gen;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        x_en = 1'b0, x_restart = 1'b0;
  logic        s_en = 1'b0, s_restart = 1'b0;

  logic [11:0] x_h, x_v;
  logic        x_hsync, x_vsync, x_hblnk, x_vblnk, x_de, x_ls, x_fs;
  logic [3:0]  s_h, s_v;
  logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_de, s_ls, s_fs;

  int n_checks = 0;
  int n_fail   = 0;
  int xh = 0, xv = 0, sh = 0, sv = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen u_dut_x (
    .pclk(pclk), .reset(reset), .en(x_en), .restart(x_restart),
    .hcount(x_h), .vcount(x_v), .hsync(x_hsync), .vsync(x_vsync),
    .hblnk(x_hblnk), .vblnk(x_vblnk), .de(x_de),
    .line_start(x_ls), .frame_start(x_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CNT_W(4)
  ) u_dut_s (
    .pclk(pclk), .reset(reset), .en(s_en), .restart(s_restart),
    .hcount(s_h), .vcount(s_v), .hsync(s_hsync), .vsync(s_vsync),
    .hblnk(s_hblnk), .vblnk(s_vblnk), .de(s_de),
    .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_x();
    logic hb, vb;
    hb = (xh >= 1024);
    vb = (xv >= 768);
    check("x_hcount", 32'(x_h), 32'(xh));
    check("x_vcount", 32'(x_v), 32'(xv));
    check("x_hblnk", 32'(x_hblnk), 32'(hb));
    check("x_vblnk", 32'(x_vblnk), 32'(vb));
    check("x_hsync", 32'(x_hsync), 32'((xh >= 1048) && (xh <= 1183)));
    check("x_vsync", 32'(x_vsync), 32'((xv >= 771) && (xv <= 776)));
    check("x_de", 32'(x_de), 32'(!hb && !vb));
    check("x_line_start", 32'(x_ls), 32'(xh == 0));
    check("x_frame_start", 32'(x_fs), 32'((xh == 0) && (xv == 0)));
  endtask

  task automatic check_s();
    logic hb, vb;
    hb = (sh >= 8);
    vb = (sv >= 4);
    check("s_hcount", 32'(s_h), 32'(sh));
    check("s_vcount", 32'(s_v), 32'(sv));
    check("s_hblnk", 32'(s_hblnk), 32'(hb));
    check("s_vblnk", 32'(s_vblnk), 32'(vb));
    check("s_hsync", 32'(s_hsync), 32'(!((sh >= 10) && (sh <= 11))));
    check("s_vsync", 32'(s_vsync), 32'(sv == 5));
    check("s_de", 32'(s_de), 32'(!hb && !vb));
    check("s_line_start", 32'(s_ls), 32'(sh == 0));
    check("s_frame_start", 32'(s_fs), 32'((sh == 0) && (sv == 0)));
  endtask

  task automatic x_tick();
    logic adv_en, adv_rs;
    adv_en = x_en;
    adv_rs = x_restart;
    @(posedge pclk);
    #1;
    if (adv_rs) begin
      xh = 0; xv = 0;
    end else if (adv_en) begin
      if (xh == 1343) begin
        xh = 0;
        xv = (xv == 805) ? 0 : xv + 1;
      end else begin
        xh++;
      end
    end
    check_x();
  endtask

  task automatic s_tick();
    logic adv_en, adv_rs;
    adv_en = s_en;
    adv_rs = s_restart;
    @(posedge pclk);
    #1;
    if (adv_rs) begin
      sh = 0; sv = 0;
    end else if (adv_en) begin
      if (sh == 13) begin
        sh = 0;
        sv = (sv == 6) ? 0 : sv + 1;
      end else begin
        sh++;
      end
    end
    check_s();
  endtask

  initial begin
    int cyc, last_f, last_l, de_cnt;
    #1 reset = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check_x();
    check_s();

    // XGA: one full line plus the wrap into line 1
    reset = 1'b1;
    x_en  = 1'b1;
    repeat (1348) x_tick();

    // stall for 7 cycles at hcount 500
    while (xh != 500) x_tick();
    x_en = 1'b0;
    repeat (7) x_tick();
    x_en = 1'b1;
    x_tick();
    check("x_resume_after_stall", 32'(x_h), 32'd501);

    // restart while running, then while stalled
    while (xh != 700) x_tick();
    x_restart = 1'b1;
    x_tick();
    x_restart = 1'b0;
    repeat (3) x_tick();
    while (xh != 700) x_tick();
    x_en = 1'b0;
    x_restart = 1'b1;
    x_tick();
    x_restart = 1'b0;
    repeat (3) x_tick();
    x_en = 1'b1;

    // asynchronous reset in mid-cycle inside hblank
    while (xh != 1100) x_tick();
    #2 reset = 1'b0;
    #1;
    xh = 0; xv = 0;
    check_x();
    @(posedge pclk);
    #1;
    check_x();
    reset = 1'b1;
    repeat (20) x_tick();
    x_en = 1'b0;

    // tiny mode: frame and line periods, de count over three frames
    s_en = 1'b1;
    cyc = 0; last_f = -1; last_l = -1; de_cnt = 0;
    repeat (3 * 98) begin
      s_tick();
      cyc++;
      if (s_fs) begin
        if (last_f >= 0) check("s_frame_period", 32'(cyc - last_f), 32'd98);
        last_f = cyc;
      end
      if (s_ls) begin
        if (last_l >= 0) check("s_line_period", 32'(cyc - last_l), 32'd14);
        last_l = cyc;
      end
      if (s_de) de_cnt++;
    end
    check("s_de_per_3_frames", 32'(de_cnt), 32'd96);

    // restart coinciding with the natural frame wrap
    while (!((sh == 13) && (sv == 6))) s_tick();
    s_restart = 1'b1;
    s_tick();
    s_restart = 1'b0;
    repeat (2) s_tick();

    // asynchronous reset during vsync
    while (!((sh == 3) && (sv == 5))) s_tick();
    #2 reset = 1'b0;
    #1;
    sh = 0; sv = 0;
    check_s();
    @(posedge pclk);
    #1;
    reset = 1'b1;
    repeat (16) s_tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/XGA raster timing generator, successor to the fixed 1024x768 timing block. It produces pixel and line counters, sync, blanking and data-enable signals for any display mode selected at elaboration. It adds configurable sync polarity, a pixel-advance enable, a synchronous frame restart, and frame/line start strobes. It sits at the head of the video pipeline, clocked by pclk, and feeds the drawing and overlay blocks.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines)
HSYNC_POL, 1, hsync active level (1 = active-high)
VSYNC_POL, 1, vsync active level
CNT_W, 12, counter width; elaboration error if H_TOTAL or V_TOTAL exceeds 2^CNT_W

Ports:
pclk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset (asserts immediately, releases on pclk edge)
en  in  1  pixel advance enable; when low all outputs hold
restart  in  1  synchronous frame restart request
hcount  out  CNT_W  current pixel in line
vcount  out  CNT_W  current line in frame
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
hblnk  out  1  horizontal blanking
vblnk  out  1  vertical blanking
de  out  1  active video (not hblnk and not vblnk)
line_start  out  1  one-cycle strobe, hcount==0
frame_start  out  1  one-cycle strobe, hcount==0 and vcount==0

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- All outputs are registered and mutually consistent: every flag in a cycle describes the hcount/vcount shown in that same cycle. Flags are decoded from the next-state counts.
- Reset (reset=0): hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=1, frame_start=1. This represents the (0,0) position.
- Advance (en=1): hcount increments. At hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments. At vcount==V_TOTAL-1 together with the h wrap, vcount wraps to 0.
- hblnk=1 iff hcount in [H_ACTIVE, H_TOTAL-1].
- hsync active iff hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vblnk=1 iff vcount in [V_ACTIVE, V_TOTAL-1]. It is constant across the whole line.
- vsync active iff vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes only at hcount 0.
- de = ~hblnk & ~vblnk.
- line_start=1 iff hcount==0. frame_start=1 iff hcount==0 and vcount==0.
- Strobes are single-cycle only while en=1. When en=0, every output including the strobes holds its value.
- Stall (en=0): counters and flags frozen, no state change.
- restart=1: next cycle is forced to the reset position (0,0) with the same output values as reset. This happens regardless of en; restart has priority over en.
- restart asserted on the cycle the counters would naturally wrap to (0,0) gives the same result, with no double strobe.
- Reset asserted mid-frame: outputs go to reset values immediately and asynchronously. Counting resumes from (0,0) on the first pclk edge after release.
- Counter arithmetic is CNT_W-bit unsigned. Values >= H_TOTAL or V_TOTAL are unreachable.

Decomposition:
- Shared package vga_timing_pkg holds:
  - mode constant sets XGA_1024x768_60 (above defaults) and SVGA_800x600_60 (800/40/128/88, 600/1/4/23);
  - a localparam function computing totals.
- Natural sub-module: timing_axis, instantiated twice (horizontal and vertical).
  - Parameters: ACTIVE/FP/SYNC/BP/POL/CNT_W.
  - Inputs: step, clear.
  - Outputs: count, blnk, sync, wrap.
  - The horizontal instance steps on en. The vertical instance steps on en & h_wrap. Both clear on restart.

Test Plan:
- Reset then en=1 with defaults, run 1 line → hblnk rises at hcount 1024; hsync high at 1048..1183; hcount wraps 1343→0; vcount 0→1; line_start high at hcount 0 only.
- Run full default frame → vblnk rises at vcount 768; vsync high for lines 771..776; frame_start pulses once per 1344*806 = 1,083,264 cycles; de pixel count per frame = 786,432.
- Small mode (H 8/2/2/2, V 4/1/1/1, HSYNC_POL=0) → hsync low only at hcount 10..11; reset value hsync=1; line period 14 cycles; frame period 98 cycles.
- Toggle en low at hcount=500 for 7 cycles → all outputs frozen 7 cycles; no extra strobes; sequence resumes at 501.
- Pulse restart at (h=700, v=300), including once with en=0 → next cycle h=0, v=0, frame_start=1, de=1.
- Assert reset asynchronously at (h=1100, v=770) mid-cycle → outputs reach reset values before the next pclk edge; counting restarts from 0 after release.
